// File: rtl/pin_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pin_bridge_pkg                                            |
// | Purpose  : Shared types, default sizing constants and helpers for    |
// |            the host-side pin bridge.                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package pin_bridge_pkg;

  // Snapshot handshake state
  typedef enum logic [0:0] {
    SNAP_IDLE  = 1'b0,
    SNAP_VALID = 1'b1
  } snap_state_t;

  // Default sizing for the lab board
  localparam int c_N_SW           = 10;
  localparam int c_N_PB           = 2;
  localparam int c_N_LED          = 10;
  localparam int c_N_SEG          = 6;
  localparam int c_N_PARAM        = 3;
  localparam int c_PARAM_W        = 32;
  localparam int c_STARTUP_CYCLES = 255;
  localparam int c_PB_MIN_CYCLES  = 1000;

  // Width of an index into N entries, never narrower than one bit
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pin_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pin_bridge_if                                             |
// | Purpose  : Bundle of host-PIO and student-side signals of the pin    |
// |            bridge. Names are seen from the bridge: i_* enter the     |
// |            bridge, o_* leave it.                                     |
// |   master : host PIO / student side (drives i_*, observes o_*)        |
// |   slave  : pin_bridge (observes i_*, drives o_*)                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface pin_bridge_if
  import pin_bridge_pkg::*;
#(
  parameter int N_SW    = c_N_SW,
  parameter int N_PB    = c_N_PB,
  parameter int N_LED   = c_N_LED,
  parameter int N_SEG   = c_N_SEG,
  parameter int N_PARAM = c_N_PARAM,
  parameter int PARAM_W = c_PARAM_W
);
  localparam int c_SEL_W = sel_width(N_PARAM);

  // start-up hold
  logic                         o_host_rst_n;
  // switches / pushbuttons
  logic [N_SW-1:0]              i_host_sw;
  logic [N_PB-1:0]              i_host_pb;
  logic [N_SW-1:0]              o_sws;
  logic [N_PB-1:0]              o_pbs;
  // parameter words
  logic [c_SEL_W-1:0]           i_host_param_sel;
  logic [PARAM_W-1:0]           i_host_param_wdata;
  logic                         i_host_param_we;
  logic                         i_host_param_commit;
  logic [N_PARAM*PARAM_W-1:0]   o_params;
  logic                         o_param_update;
  // display snapshot
  logic [N_LED-1:0]             i_leds;
  logic [8*N_SEG-1:0]           i_seg7;
  logic                         i_host_snap_req;
  logic                         i_host_snap_ack;
  logic [N_LED-1:0]             o_host_leds;
  logic [8*N_SEG-1:0]           o_host_seg;
  logic                         o_host_snap_valid;

  modport master (
    input  o_host_rst_n, o_sws, o_pbs, o_params, o_param_update,
           o_host_leds, o_host_seg, o_host_snap_valid,
    output i_host_sw, i_host_pb, i_host_param_sel, i_host_param_wdata,
           i_host_param_we, i_host_param_commit, i_leds, i_seg7,
           i_host_snap_req, i_host_snap_ack
  );

  modport slave (
    output o_host_rst_n, o_sws, o_pbs, o_params, o_param_update,
           o_host_leds, o_host_seg, o_host_snap_valid,
    input  i_host_sw, i_host_pb, i_host_param_sel, i_host_param_wdata,
           i_host_param_we, i_host_param_commit, i_leds, i_seg7,
           i_host_snap_req, i_host_snap_ack
  );

endinterface
`default_nettype wire

// File: rtl/pin_bridge_pb_stretch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pb_stretch                                                |
// | Purpose  : One pushbutton lane: two-flop synchroniser, edge-detect   |
// |            flop and a pulse-stretch down-counter.                    |
// |   clk, rst : clock, synchronous active-high reset                    |
// |   i_en     : 0 forces the output low and holds the counter at 0      |
// |   i_pb     : raw (asynchronous) button bit, active high              |
// |   o_pb     : synchronised, stretched button bit                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pb_stretch #(
  parameter int PB_MIN_CYCLES = 1000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_en,
  input  wire logic i_pb,
  output logic      o_pb
);
  localparam int c_CNT_W = $clog2(PB_MIN_CYCLES + 1);
  // The counter is loaded on the edge after the synced bit rises, so the
  // synced cycle plus PB_MIN_CYCLES counted cycles give a one-cycle press
  // a high time of PB_MIN_CYCLES+1.
  localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(PB_MIN_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_rise;

  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_pb;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (!i_en) begin
        r_cnt <= '0;
      end else if (w_rise) begin
        // a fresh press during a stretch restarts it
        r_cnt <= c_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - c_ONE;
      end
    end
  end

  assign o_pb = i_en & (r_s2 | (r_cnt != '0));

endmodule
`default_nettype wire

// File: rtl/pin_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pin_bridge                                                |
// | Purpose  : Host-side pin bridge between the JTAG host PIO and the    |
// |            student top level: start-up hold, switch sync, button     |
// |            stretch, atomic parameter words, display snapshot.        |
// |   clk, rst : clock, synchronous active-high reset                    |
// |   if_bus   : pin_bridge_if slave port carrying                       |
// |     o_host_rst_n                      start-up hold (active low)     |
// |     i_host_sw/o_sws                   switches in / synchronised     |
// |     i_host_pb/o_pbs                   buttons in / stretched         |
// |     i_host_param_* / o_params         shadow write, commit, live     |
// |     o_param_update                    one-cycle pulse per commit     |
// |     i_leds/i_seg7                     student display outputs        |
// |     i_host_snap_req/ack, o_host_*     snapshot handshake and data    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pin_bridge
  import pin_bridge_pkg::*;
#(
  parameter int N_SW           = c_N_SW,
  parameter int N_PB           = c_N_PB,
  parameter int N_LED          = c_N_LED,
  parameter int N_SEG          = c_N_SEG,
  parameter int N_PARAM        = c_N_PARAM,
  parameter int PARAM_W        = c_PARAM_W,
  parameter int STARTUP_CYCLES = c_STARTUP_CYCLES,
  parameter int PB_MIN_CYCLES  = c_PB_MIN_CYCLES
) (
  input wire logic     clk,
  input wire logic     rst,
  pin_bridge_if.slave  if_bus
);
  localparam int c_SEL_W   = sel_width(N_PARAM);
  localparam int c_START_W = $clog2(STARTUP_CYCLES + 1);
  localparam logic [c_START_W-1:0] c_START_MAX = c_START_W'(STARTUP_CYCLES);
  localparam logic [c_START_W-1:0] c_START_ONE = c_START_W'(1);

  // ------------------------------------------------------------------
  // Start-up hold: count up to STARTUP_CYCLES, then release the host.
  // ------------------------------------------------------------------
  logic [c_START_W-1:0] r_start_cnt;
  logic                 r_host_rst_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_cnt  <= '0;
      r_host_rst_n <= 1'b0;
    end else begin
      if (r_start_cnt != c_START_MAX) begin
        r_start_cnt <= r_start_cnt + c_START_ONE;
      end
      r_host_rst_n <= (r_start_cnt == c_START_MAX);
    end
  end

  assign if_bus.o_host_rst_n = r_host_rst_n;

  // ------------------------------------------------------------------
  // Switches: two-flop synchroniser, output gated during the hold.
  // ------------------------------------------------------------------
  logic [N_SW-1:0] r_sw_s1;
  logic [N_SW-1:0] r_sw_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= if_bus.i_host_sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign if_bus.o_sws = r_host_rst_n ? r_sw_s2 : '0;

  // ------------------------------------------------------------------
  // Pushbuttons: one stretch lane per bit.
  // ------------------------------------------------------------------
  logic [N_PB-1:0] w_pbs;

  for (genvar g = 0; g < N_PB; g++) begin : g_pb
    pb_stretch #(
      .PB_MIN_CYCLES(PB_MIN_CYCLES)
    ) u_pb_stretch (
      .clk  (clk),
      .rst  (rst),
      .i_en (r_host_rst_n),
      .i_pb (if_bus.i_host_pb[g]),
      .o_pb (w_pbs[g])
    );
  end

  assign if_bus.o_pbs = w_pbs;

  // ------------------------------------------------------------------
  // Parameter words: shadow registers plus an atomic copy to the live
  // words. A write in the commit cycle is forwarded into the commit.
  // Out-of-range selects match no entry and are thereby ignored.
  // ------------------------------------------------------------------
  logic [PARAM_W-1:0]         r_shadow [N_PARAM];
  logic [N_PARAM*PARAM_W-1:0] r_params;
  logic                       r_param_update;
  logic [N_PARAM-1:0]         w_wr_hit;

  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < N_PARAM; i++) begin
      w_wr_hit[i] = if_bus.i_host_param_we &&
                    (if_bus.i_host_param_sel == c_SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PARAM; i++) begin
        r_shadow[i] <= '0;
      end
      r_params       <= '0;
      r_param_update <= 1'b0;
    end else begin
      r_param_update <= if_bus.i_host_param_commit;
      for (int i = 0; i < N_PARAM; i++) begin
        if (w_wr_hit[i]) begin
          r_shadow[i] <= if_bus.i_host_param_wdata;
        end
        if (if_bus.i_host_param_commit) begin
          r_params[i*PARAM_W +: PARAM_W] <= w_wr_hit[i] ? if_bus.i_host_param_wdata
                                                        : r_shadow[i];
        end
      end
    end
  end

  assign if_bus.o_params       = r_params;
  assign if_bus.o_param_update = r_param_update;

  // ------------------------------------------------------------------
  // Snapshot FSM: capture on request, hold until acknowledged. A request
  // arriving together with the acknowledge re-arms with fresh data.
  // ------------------------------------------------------------------
  snap_state_t        r_snap_state;
  logic               r_snap_valid;
  logic [N_LED-1:0]   r_host_leds;
  logic [8*N_SEG-1:0] r_host_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_state <= SNAP_IDLE;
      r_snap_valid <= 1'b0;
      r_host_leds  <= '0;
      r_host_seg   <= '0;
    end else begin
      case (r_snap_state)
        SNAP_IDLE: begin
          if (if_bus.i_host_snap_req) begin
            r_host_leds  <= if_bus.i_leds;
            r_host_seg   <= if_bus.i_seg7;
            r_snap_state <= SNAP_VALID;
            r_snap_valid <= 1'b1;
          end
        end
        SNAP_VALID: begin
          if (if_bus.i_host_snap_ack) begin
            if (if_bus.i_host_snap_req) begin
              r_host_leds <= if_bus.i_leds;
              r_host_seg  <= if_bus.i_seg7;
            end else begin
              r_snap_state <= SNAP_IDLE;
              r_snap_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_snap_state <= SNAP_IDLE;
          r_snap_valid <= 1'b0;
        end
      endcase
    end
  end

  assign if_bus.o_host_leds       = r_host_leds;
  assign if_bus.o_host_seg        = r_host_seg;
  assign if_bus.o_host_snap_valid = r_snap_valid;

endmodule
`default_nettype wire

// File: tb/tb_pin_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pin_bridge                                             |
// | Purpose  : Self-checking bench for pin_bridge: directed start-up,    |
// |            switch and pushbutton sequences, a vector table for the   |
// |            parameter / snapshot paths, and a randomised phase        |
// |            compared against a behavioural model.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pin_bridge;
  import pin_bridge_pkg::*;

  localparam int N_SW    = 10;
  localparam int N_PB    = 2;
  localparam int N_LED   = 10;
  localparam int N_SEG   = 6;
  localparam int N_PARAM = 3;
  localparam int PARAM_W = 32;
  localparam int STARTUP = 255;
  localparam int PB_MIN  = 1000;
  localparam int N_RAND  = 2500;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pin_bridge_if #(
    .N_SW(N_SW), .N_PB(N_PB), .N_LED(N_LED), .N_SEG(N_SEG),
    .N_PARAM(N_PARAM), .PARAM_W(PARAM_W)
  ) bus ();

  pin_bridge #(
    .N_SW(N_SW), .N_PB(N_PB), .N_LED(N_LED), .N_SEG(N_SEG),
    .N_PARAM(N_PARAM), .PARAM_W(PARAM_W),
    .STARTUP_CYCLES(STARTUP), .PB_MIN_CYCLES(PB_MIN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .if_bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // count edges until host_rst_n rises; also count gating violations
  task automatic wait_rise(output int edges, output int bad);
    edges = 0;
    bad   = 0;
    while (bus.o_host_rst_n !== 1'b1 && edges < 2*STARTUP + 20) begin
      tick();
      edges++;
      if (bus.o_host_rst_n !== 1'b1 && (bus.o_sws !== '0 || bus.o_pbs !== '0)) bad++;
    end
  endtask

  // parameter / snapshot vector table
  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        commit;
    logic        req;
    logic        ack;
    logic [9:0]  leds;
    logic [47:0] seg;
    logic [95:0] e_params;
    logic        e_upd;
    logic        e_valid;
    logic [9:0]  e_leds;
    logic [47:0] e_seg;
  } vec_t;

  vec_t vecs [13];

  // behavioural model state for the randomised phase
  logic [31:0] m_shadow [N_PARAM];
  logic [95:0] m_params;
  logic        m_valid;
  logic [9:0]  m_leds;
  logic [47:0] m_seg;
  logic [9:0]  m_sw_prev;
  logic [1:0]  m_pb_prev, m_pb_prev2;
  int          m_last_rise [N_PB];

  initial begin
    int edges, bad, hi, first, last, bad1;
    logic [95:0] p1, p2, p3;
    logic [9:0]  sw_now;
    logic [1:0]  pb_now, exp_pbs;
    logic        we, commit, req, ack;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic [9:0]  leds;
    logic [47:0] seg;

    p1 = {32'h0, 32'hDEADBEEF, 32'h0};
    p2 = {32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
    p3 = {32'hCAFEF00D, 32'hDEADBEEF, 32'h11111111};
    //            we   sel   wdata          cm   rq   ak   leds     seg                params upd  val  e_leds   e_seg
    vecs[0]  = '{1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 10'h2AA, 48'hC0,          96'h0, 1'b0, 1'b0, 10'h0,   48'h0};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 10'h2AA, 48'hC0,          96'h0, 1'b0, 1'b0, 10'h0,   48'h0};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 10'h2AA, 48'hC0,          p1,    1'b1, 1'b0, 10'h0,   48'h0};
    vecs[3]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 10'h2AA, 48'hC0,          p1,    1'b0, 1'b0, 10'h0,   48'h0};
    vecs[4]  = '{1'b1, 2'd3, 32'h12345678, 1'b0, 1'b0, 1'b0, 10'h2AA, 48'hC0,          p1,    1'b0, 1'b0, 10'h0,   48'h0};
    vecs[5]  = '{1'b1, 2'd2, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 10'h2AA, 48'hC0,          p2,    1'b1, 1'b0, 10'h0,   48'h0};
    vecs[6]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b0, 10'h2AA, 48'hC0,          p2,    1'b0, 1'b1, 10'h2AA, 48'hC0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b0, 10'h155, 48'hF9,          p2,    1'b0, 1'b1, 10'h2AA, 48'hC0};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b1, 10'h155, 48'hF9,          p2,    1'b0, 1'b1, 10'h155, 48'hF9};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1, 10'h000, 48'h0,           p2,    1'b0, 1'b0, 10'h155, 48'hF9};
    vecs[10] = '{1'b1, 2'd3, 32'h12345678, 1'b1, 1'b0, 1'b0, 10'h000, 48'h0,           p2,    1'b1, 1'b0, 10'h155, 48'hF9};
    vecs[11] = '{1'b1, 2'd0, 32'h11111111, 1'b0, 1'b1, 1'b0, 10'h3FF, 48'hA40000000000, p2,    1'b0, 1'b1, 10'h3FF, 48'hA40000000000};
    vecs[12] = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b1, 10'h3FF, 48'h0,           p3,    1'b1, 1'b0, 10'h3FF, 48'hA40000000000};

    // ---------------- reset state and start-up hold ----------------
    bus.i_host_sw = 10'h3FF;  bus.i_host_pb = 2'b11;
    bus.i_host_param_sel = '0; bus.i_host_param_wdata = '0;
    bus.i_host_param_we = 1'b0; bus.i_host_param_commit = 1'b0;
    bus.i_leds = '0; bus.i_seg7 = '0;
    bus.i_host_snap_req = 1'b0; bus.i_host_snap_ack = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_host_rst_n", bus.o_host_rst_n, 1'b0);
    check("rst_sws", bus.o_sws, 10'h0);
    check("rst_pbs", bus.o_pbs, 2'b00);
    check("rst_param_update", bus.o_param_update, 1'b0);
    check("rst_params", bus.o_params, 96'h0);
    check("rst_snap", {bus.o_host_snap_valid, bus.o_host_leds, bus.o_host_seg}, 59'h0);
    rst = 1'b0;
    wait_rise(edges, bad);
    check("startup_edges", edges, STARTUP + 1);
    check("hold_gating", bad, 0);
    check("sws_after_hold", bus.o_sws, 10'h3FF);
    // button held through the hold: follows the input, no stretch
    check("pbs_after_hold", bus.o_pbs, 2'b11);
    bus.i_host_pb = 2'b00;
    tick(); tick();
    check("pb_no_stretch_from_hold", bus.o_pbs, 2'b00);

    // restart of the hold by a late reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (100) tick();
    check("hold_at_100", bus.o_host_rst_n, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_rise(edges, bad);
    check("restart_edges", edges, STARTUP + 1);
    check("restart_gating", bad, 0);

    // ---------------- switch synchroniser latency ----------------
    bus.i_host_sw = 10'h155;
    tick();
    check("sws_lat1", bus.o_sws, 10'h3FF);
    tick();
    check("sws_lat2", bus.o_sws, 10'h155);

    // ---------------- parameter / snapshot vector table ----------------
    for (int i = 0; i < 13; i++) begin
      bus.i_host_param_we     = vecs[i].we;
      bus.i_host_param_sel    = vecs[i].sel;
      bus.i_host_param_wdata  = vecs[i].wdata;
      bus.i_host_param_commit = vecs[i].commit;
      bus.i_host_snap_req     = vecs[i].req;
      bus.i_host_snap_ack     = vecs[i].ack;
      bus.i_leds              = vecs[i].leds;
      bus.i_seg7              = vecs[i].seg;
      tick();
      check($sformatf("vec%0d_params", i), bus.o_params, vecs[i].e_params);
      check($sformatf("vec%0d_update", i), bus.o_param_update, vecs[i].e_upd);
      check($sformatf("vec%0d_valid", i), bus.o_host_snap_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_snapdata", i), {bus.o_host_leds, bus.o_host_seg},
            {vecs[i].e_leds, vecs[i].e_seg});
    end
    bus.i_host_param_we = 1'b0; bus.i_host_param_commit = 1'b0;
    bus.i_host_snap_req = 1'b0; bus.i_host_snap_ack = 1'b0;

    // ---------------- pushbutton stretch: single pulse ----------------
    hi = 0; first = -1; last = -1; bad1 = 0;
    for (int t = 0; t < 1200; t++) begin
      bus.i_host_pb = (t == 0) ? 2'b01 : 2'b00;
      tick();
      if (bus.o_pbs[0]) begin hi++; if (first < 0) first = t; last = t; end
      if (bus.o_pbs[1]) bad1++;
    end
    check("pb_single_high", hi, PB_MIN + 1);
    check("pb_single_first", first, 1);
    check("pb_single_contig", last - first + 1, PB_MIN + 1);
    check("pb1_quiet", bad1, 0);

    // ---------------- pushbutton stretch: reload mid-stretch ----------------
    hi = 0; first = -1; last = -1;
    for (int t = 0; t < 2000; t++) begin
      bus.i_host_pb = (t == 0 || t == 500) ? 2'b01 : 2'b00;
      tick();
      if (bus.o_pbs[0]) begin hi++; if (first < 0) first = t; last = t; end
    end
    check("pb_reload_high", hi, 500 + PB_MIN + 1);
    check("pb_reload_contig", last - first + 1, 500 + PB_MIN + 1);

    // ---------------- randomised phase against the model ----------------
    bus.i_host_sw = '0; bus.i_host_pb = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    wait_rise(edges, bad);
    check("rand_startup_edges", edges, STARTUP + 1);
    for (int i = 0; i < N_PARAM; i++) m_shadow[i] = '0;
    m_params = '0; m_valid = 1'b0; m_leds = '0; m_seg = '0;
    m_sw_prev = '0; m_pb_prev = '0; m_pb_prev2 = '0;
    for (int b = 0; b < N_PB; b++) m_last_rise[b] = -1000000;
    pb_now = '0;

    for (int t = 0; t < N_RAND; t++) begin
      sw_now = 10'($urandom);
      for (int b = 0; b < N_PB; b++) begin
        if (pb_now[b]) pb_now[b] = ($urandom_range(3, 0) != 0);
        else           pb_now[b] = ($urandom_range(699, 0) == 0);
      end
      we     = ($urandom_range(3, 0) == 0);
      sel    = 2'($urandom_range(3, 0));
      wdata  = $urandom;
      commit = ($urandom_range(7, 0) == 0);
      req    = ($urandom_range(2, 0) == 0);
      ack    = ($urandom_range(2, 0) == 0);
      leds   = 10'($urandom);
      seg    = 48'({$urandom, $urandom});
      bus.i_host_sw = sw_now;  bus.i_host_pb = pb_now;
      bus.i_host_param_we = we; bus.i_host_param_sel = sel;
      bus.i_host_param_wdata = wdata; bus.i_host_param_commit = commit;
      bus.i_host_snap_req = req; bus.i_host_snap_ack = ack;
      bus.i_leds = leds; bus.i_seg7 = seg;
      tick();

      // pushbuttons: synced value is the one sampled one edge earlier;
      // high while synced or within PB_MIN cycles of the last synced rise
      for (int b = 0; b < N_PB; b++) begin
        if (m_pb_prev[b] && !m_pb_prev2[b]) m_last_rise[b] = t;
        exp_pbs[b] = m_pb_prev[b] || ((t - m_last_rise[b]) <= PB_MIN);
      end
      check("rand_sws", bus.o_sws, m_sw_prev);
      check("rand_pbs", bus.o_pbs, exp_pbs);
      m_sw_prev  = sw_now;
      m_pb_prev2 = m_pb_prev;
      m_pb_prev  = pb_now;

      // parameters: write first, then commit copies every shadow
      if (we && int'(sel) < N_PARAM) m_shadow[sel] = wdata;
      if (commit) for (int i = 0; i < N_PARAM; i++) m_params[i*32 +: 32] = m_shadow[i];
      check("rand_params", bus.o_params, m_params);
      check("rand_update", bus.o_param_update, commit);

      // snapshot handshake
      if (!m_valid) begin
        if (req) begin m_valid = 1'b1; m_leds = leds; m_seg = seg; end
      end else if (ack) begin
        if (req) begin m_leds = leds; m_seg = seg; end
        else m_valid = 1'b0;
      end
      check("rand_snap_valid", bus.o_host_snap_valid, m_valid);
      check("rand_snap_data", {bus.o_host_leds, bus.o_host_seg}, {m_leds, m_seg});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
